// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write-back path.
// The grant encoding names which requester owns the single write port this cycle.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Precedence at the edge: flush clears everything, otherwise a new set beats a same-cycle commit.
module wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // x0 is never marked, so busy[0] stays 0 and the query needs no special case
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_rd != '0)
            set_mask[set_rd] = 1'b1;
        if (clr_en)
            clr_mask[clr_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            busy <= '0;
        else if (flush)
            busy <= '0;
        else
            busy <= (busy & ~clr_mask) | set_mask;
    end

    assign rs1_busy = busy[rs1_addr];
    assign rs2_busy = busy[rs2_addr];

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates ALU and LSU onto the register-file write port
// through one register stage and tracks pending destinations for hazard stalls.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int NUM_REGS     = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [REG_ADDR_W-1:0] alu_rd_i,
    input  logic [XLEN-1:0]       alu_data_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [REG_ADDR_W-1:0] lsu_rd_i,
    input  logic [XLEN-1:0]       lsu_data_i,
    input  logic                  sb_set_i,
    input  logic [REG_ADDR_W-1:0] sb_set_rd_i,
    input  logic                  flush_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rf_wr_en_o,
    output logic [REG_ADDR_W-1:0] rf_rd_addr_o,
    output logic [XLEN-1:0]       rf_wr_data_o
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    wb_src_e               grant;
    logic [CNT_W-1:0]      starve_cnt;
    logic [REG_ADDR_W-1:0] win_rd;
    logic [XLEN-1:0]       win_data;

    // LSU normally wins; a starved ALU takes the port once its loss count saturates
    always_comb begin
        grant = WB_NONE;
        if (reset_n) begin
            if (alu_valid_i && (!lsu_valid_i || starve_cnt == CNT_MAX))
                grant = WB_ALU;
            else if (lsu_valid_i)
                grant = WB_LSU;
        end
    end

    assign alu_ready_o = (grant == WB_ALU);
    assign lsu_ready_o = (grant == WB_LSU);

    always_comb begin
        win_rd   = lsu_rd_i;
        win_data = lsu_data_i;
        if (grant == WB_ALU) begin
            win_rd   = alu_rd_i;
            win_data = alu_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            starve_cnt <= '0;
        else if (!alu_valid_i || alu_ready_o)
            starve_cnt <= '0;
        else if (starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Writes to x0 still complete the handshake but never reach the register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_wr_en_o   <= 1'b0;
            rf_rd_addr_o <= '0;
            rf_wr_data_o <= '0;
        end else if (grant != WB_NONE) begin
            rf_wr_en_o   <= (win_rd != '0);
            rf_rd_addr_o <= win_rd;
            rf_wr_data_o <= win_data;
        end else begin
            rf_wr_en_o   <= 1'b0;
        end
    end

    wb_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .set_en   (sb_set_i),
        .set_rd   (sb_set_rd_i),
        .clr_en   (rf_wr_en_o),
        .clr_rd   (rf_rd_addr_o),
        .flush    (flush_i),
        .rs1_addr (rs1_addr_i),
        .rs2_addr (rs2_addr_i),
        .rs1_busy (rs1_busy_o),
        .rs2_busy (rs2_busy_o)
    );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios followed by a randomized run
// checked against a cycle-level model of arbitration, write-back and the scoreboard.
module tb_regfile_wb_ctrl;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid_i, lsu_valid_i, sb_set_i, flush_i;
    logic        alu_ready_o, lsu_ready_o, rs1_busy_o, rs2_busy_o, rf_wr_en_o;
    logic [4:0]  alu_rd_i, lsu_rd_i, sb_set_rd_i, rs1_addr_i, rs2_addr_i, rf_rd_addr_o;
    logic [31:0] alu_data_i, lsu_data_i, rf_wr_data_o;

    int errors = 0;
    int checks = 0;

    regfile_wb_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alu_valid_i  (alu_valid_i),
        .alu_ready_o  (alu_ready_o),
        .alu_rd_i     (alu_rd_i),
        .alu_data_i   (alu_data_i),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_rd_i     (lsu_rd_i),
        .lsu_data_i   (lsu_data_i),
        .sb_set_i     (sb_set_i),
        .sb_set_rd_i  (sb_set_rd_i),
        .flush_i      (flush_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_busy_o   (rs1_busy_o),
        .rs2_busy_o   (rs2_busy_o),
        .rf_wr_en_o   (rf_wr_en_o),
        .rf_rd_addr_o (rf_rd_addr_o),
        .rf_wr_data_o (rf_wr_data_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_idle();
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
        sb_set_i = 0; sb_set_rd_i = 0; flush_i = 0;
        rs1_addr_i = 0; rs2_addr_i = 0;
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 0;
        alu_valid_i = 1; lsu_valid_i = 1; alu_rd_i = 5'd3; lsu_rd_i = 5'd4;
        repeat (2) @(posedge clk);
        #4;
        checks++; if (alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b0) begin errors++;
            $display("[TB] FAIL reset_ready: got alu=%b lsu=%b expected 0 0", alu_ready_o, lsu_ready_o); end
        checks++; if (rf_wr_en_o !== 1'b0 || rf_rd_addr_o !== 5'd0 || rf_wr_data_o !== 32'd0) begin errors++;
            $display("[TB] FAIL reset_out: got en=%b addr=%0d data=%h expected 0 0 0", rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o); end
        next_cycle();
        drive_idle();
        reset_n = 1;
        next_cycle();
    endtask

    task automatic test_alu_single();
        alu_valid_i = 1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        #3;
        checks++; if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin errors++;
            $display("[TB] FAIL alu_single_ready: got alu=%b lsu=%b expected 1 0", alu_ready_o, lsu_ready_o); end
        next_cycle();
        drive_idle();
        #3;
        checks++; if (rf_wr_en_o !== 1'b1 || rf_rd_addr_o !== 5'd5 || rf_wr_data_o !== 32'hDEADBEEF) begin errors++;
            $display("[TB] FAIL alu_single_wb: got en=%b addr=%0d data=%h expected 1 5 deadbeef", rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o); end
        next_cycle();
        #3;
        checks++; if (rf_wr_en_o !== 1'b0 || rf_rd_addr_o !== 5'd5 || rf_wr_data_o !== 32'hDEADBEEF) begin errors++;
            $display("[TB] FAIL idle_hold: got en=%b addr=%0d data=%h expected 0 5 deadbeef", rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o); end
    endtask

    task automatic test_both_valid();
        next_cycle();
        alu_valid_i = 1; alu_rd_i = 5'd3; alu_data_i = 32'h11;
        lsu_valid_i = 1; lsu_rd_i = 5'd4; lsu_data_i = 32'h22;
        #3;
        checks++; if (alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b1) begin errors++;
            $display("[TB] FAIL both_first: got alu=%b lsu=%b expected 0 1", alu_ready_o, lsu_ready_o); end
        next_cycle();
        lsu_valid_i = 0;
        #3;
        checks++; if (alu_ready_o !== 1'b1) begin errors++;
            $display("[TB] FAIL both_second: got alu_ready=%b expected 1", alu_ready_o); end
        checks++; if (rf_wr_en_o !== 1'b1 || rf_rd_addr_o !== 5'd4 || rf_wr_data_o !== 32'h22) begin errors++;
            $display("[TB] FAIL both_lsu_wb: got en=%b addr=%0d data=%h expected 1 4 22", rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o); end
        next_cycle();
        drive_idle();
        #3;
        checks++; if (rf_wr_en_o !== 1'b1 || rf_rd_addr_o !== 5'd3 || rf_wr_data_o !== 32'h11) begin errors++;
            $display("[TB] FAIL both_alu_wb: got en=%b addr=%0d data=%h expected 1 3 11", rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o); end
    endtask

    task automatic test_starvation();
        next_cycle();
        alu_valid_i = 1; alu_rd_i = 5'd7; alu_data_i = 32'h77;
        for (int i = 0; i < 4; i++) begin
            lsu_valid_i = 1; lsu_rd_i = 5'(10 + i); lsu_data_i = 32'(100 + i);
            #3;
            checks++; if (alu_ready_o !== (i == 3) || lsu_ready_o !== (i != 3)) begin errors++;
                $display("[TB] FAIL starve_cycle%0d: got alu=%b lsu=%b expected %b %b", i, alu_ready_o, lsu_ready_o, i == 3, i != 3); end
            next_cycle();
        end
        alu_rd_i = 5'd8; alu_data_i = 32'h88;
        lsu_rd_i = 5'd20; lsu_data_i = 32'h200;
        #3;
        checks++; if (alu_ready_o !== 1'b0 || lsu_ready_o !== 1'b1) begin errors++;
            $display("[TB] FAIL starve_cleared: got alu=%b lsu=%b expected 0 1", alu_ready_o, lsu_ready_o); end
        checks++; if (rf_wr_en_o !== 1'b1 || rf_rd_addr_o !== 5'd7 || rf_wr_data_o !== 32'h77) begin errors++;
            $display("[TB] FAIL starve_alu_wb: got en=%b addr=%0d data=%h expected 1 7 77", rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o); end
        next_cycle();
        lsu_valid_i = 0;
        #3;
        checks++; if (alu_ready_o !== 1'b1) begin errors++;
            $display("[TB] FAIL starve_alone: got alu_ready=%b expected 1", alu_ready_o); end
        next_cycle();
        drive_idle();
    endtask

    task automatic test_scoreboard();
        next_cycle();
        sb_set_i = 1; sb_set_rd_i = 5'd9; rs1_addr_i = 5'd9;
        #3;
        checks++; if (rs1_busy_o !== 1'b0) begin errors++;
            $display("[TB] FAIL sb_before_edge: got busy=%b expected 0", rs1_busy_o); end
        next_cycle();
        sb_set_i = 0;
        alu_valid_i = 1; alu_rd_i = 5'd9; alu_data_i = 32'h99;
        #3;
        checks++; if (rs1_busy_o !== 1'b1 || alu_ready_o !== 1'b1) begin errors++;
            $display("[TB] FAIL sb_set: got busy=%b ready=%b expected 1 1", rs1_busy_o, alu_ready_o); end
        next_cycle();
        alu_valid_i = 0;
        #3;
        checks++; if (rf_wr_en_o !== 1'b1 || rf_rd_addr_o !== 5'd9 || rs1_busy_o !== 1'b1) begin errors++;
            $display("[TB] FAIL sb_commit_cycle: got en=%b addr=%0d busy=%b expected 1 9 1", rf_wr_en_o, rf_rd_addr_o, rs1_busy_o); end
        next_cycle();
        #3;
        checks++; if (rs1_busy_o !== 1'b0) begin errors++;
            $display("[TB] FAIL sb_cleared: got busy=%b expected 0", rs1_busy_o); end
    endtask

    task automatic test_set_clear_flush();
        next_cycle();
        sb_set_i = 1; sb_set_rd_i = 5'd9; rs1_addr_i = 5'd9;
        next_cycle();
        sb_set_i = 0;
        alu_valid_i = 1; alu_rd_i = 5'd9; alu_data_i = 32'h1234;
        next_cycle();
        alu_valid_i = 0;
        sb_set_i = 1; sb_set_rd_i = 5'd9;
        #3;
        checks++; if (rf_wr_en_o !== 1'b1 || rf_rd_addr_o !== 5'd9) begin errors++;
            $display("[TB] FAIL setclr_commit: got en=%b addr=%0d expected 1 9", rf_wr_en_o, rf_rd_addr_o); end
        next_cycle();
        sb_set_rd_i = 5'd12; rs2_addr_i = 5'd12;
        #3;
        checks++; if (rs1_busy_o !== 1'b1) begin errors++;
            $display("[TB] FAIL setclr_same: got busy=%b expected 1", rs1_busy_o); end
        next_cycle();
        flush_i = 1; sb_set_rd_i = 5'd13;
        #3;
        checks++; if (rs2_busy_o !== 1'b1) begin errors++;
            $display("[TB] FAIL flush_pre: got rs2 busy=%b expected 1", rs2_busy_o); end
        next_cycle();
        flush_i = 0; sb_set_i = 0;
        rs1_addr_i = 5'd13; rs2_addr_i = 5'd9;
        #3;
        checks++; if (rs1_busy_o !== 1'b0 || rs2_busy_o !== 1'b0) begin errors++;
            $display("[TB] FAIL flush_clear: got rs1=%b rs2=%b expected 0 0", rs1_busy_o, rs2_busy_o); end
        next_cycle();
        sb_set_i = 1; sb_set_rd_i = 5'd0; rs1_addr_i = 5'd0;
        next_cycle();
        sb_set_i = 0;
        #3;
        checks++; if (rs1_busy_o !== 1'b0) begin errors++;
            $display("[TB] FAIL set_x0: got busy=%b expected 0", rs1_busy_o); end
        drive_idle();
    endtask

    task automatic test_zero_rd();
        next_cycle();
        alu_valid_i = 1; alu_rd_i = 5'd0; alu_data_i = 32'hFFFF;
        #3;
        checks++; if (alu_ready_o !== 1'b1) begin errors++;
            $display("[TB] FAIL x0_ready: got %b expected 1", alu_ready_o); end
        next_cycle();
        drive_idle();
        #3;
        checks++; if (rf_wr_en_o !== 1'b0) begin errors++;
            $display("[TB] FAIL x0_wr_en: got %b expected 0", rf_wr_en_o); end
    endtask

    task automatic test_reset_midflight();
        next_cycle();
        sb_set_i = 1; sb_set_rd_i = 5'd20;
        alu_valid_i = 1; alu_rd_i = 5'd21; alu_data_i = 32'hCAFE;
        next_cycle();
        drive_idle();
        rs1_addr_i = 5'd20;
        #1;
        checks++; if (rf_wr_en_o !== 1'b1 || rs1_busy_o !== 1'b1) begin errors++;
            $display("[TB] FAIL midflight_pre: got en=%b busy=%b expected 1 1", rf_wr_en_o, rs1_busy_o); end
        reset_n = 0;
        #1;
        checks++; if (rf_wr_en_o !== 1'b0 || rf_rd_addr_o !== 5'd0 || rf_wr_data_o !== 32'd0 || rs1_busy_o !== 1'b0) begin errors++;
            $display("[TB] FAIL midflight_reset: got en=%b addr=%0d data=%h busy=%b expected 0 0 0 0", rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o, rs1_busy_o); end
        next_cycle();
        reset_n = 1;
    endtask

    task automatic test_random();
        wb_req_t     alu_req, lsu_req;
        bit          alu_pend, lsu_pend, alu_win, lsu_win;
        bit          mbusy [32];
        bit          exp_en;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        int          losses;

        next_cycle();
        drive_idle();
        reset_n = 0;
        next_cycle();
        reset_n = 1;
        for (int r = 0; r < 32; r++) mbusy[r] = 0;
        exp_en = 0; exp_addr = 0; exp_data = 0; losses = 0;
        alu_pend = 0; lsu_pend = 0;
        alu_req = '0; lsu_req = '0;

        for (int cyc = 0; cyc < 500; cyc++) begin
            next_cycle();
            if (!alu_pend && $urandom_range(0, 99) < 60) begin
                alu_pend = 1; alu_req.rd = 5'($urandom); alu_req.data = $urandom;
            end
            if (!lsu_pend && $urandom_range(0, 99) < 70) begin
                lsu_pend = 1; lsu_req.rd = 5'($urandom); lsu_req.data = $urandom;
            end
            alu_valid_i = alu_pend; alu_rd_i = alu_req.rd; alu_data_i = alu_req.data;
            lsu_valid_i = lsu_pend; lsu_rd_i = lsu_req.rd; lsu_data_i = lsu_req.data;
            sb_set_i    = ($urandom_range(0, 99) < 40);
            sb_set_rd_i = 5'($urandom);
            flush_i     = ($urandom_range(0, 99) < 4);
            rs1_addr_i  = 5'($urandom);
            rs2_addr_i  = 5'($urandom);
            #3;

            alu_win = alu_pend && (!lsu_pend || losses >= 3);
            lsu_win = lsu_pend && !alu_win;
            checks++; if (alu_ready_o !== alu_win || lsu_ready_o !== lsu_win) begin errors++;
                $display("[TB] FAIL rand_grant c%0d: got alu=%b lsu=%b expected %b %b", cyc, alu_ready_o, lsu_ready_o, alu_win, lsu_win); end
            checks++; if (rf_wr_en_o !== exp_en || (exp_en && (rf_rd_addr_o !== exp_addr || rf_wr_data_o !== exp_data))) begin errors++;
                $display("[TB] FAIL rand_wb c%0d: got en=%b addr=%0d data=%h expected %b %0d %h", cyc, rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o, exp_en, exp_addr, exp_data); end
            checks++; if (rs1_busy_o !== mbusy[rs1_addr_i] || rs2_busy_o !== mbusy[rs2_addr_i]) begin errors++;
                $display("[TB] FAIL rand_busy c%0d: got rs1=%b rs2=%b expected %b %b", cyc, rs1_busy_o, rs2_busy_o, mbusy[rs1_addr_i], mbusy[rs2_addr_i]); end

            if (flush_i) begin
                for (int r = 0; r < 32; r++) mbusy[r] = 0;
            end else begin
                if (exp_en) mbusy[exp_addr] = 0;
                if (sb_set_i && sb_set_rd_i != 0) mbusy[sb_set_rd_i] = 1;
            end
            if (alu_win) begin
                exp_en = (alu_req.rd != 0); exp_addr = alu_req.rd; exp_data = alu_req.data;
            end else if (lsu_win) begin
                exp_en = (lsu_req.rd != 0); exp_addr = lsu_req.rd; exp_data = lsu_req.data;
            end else begin
                exp_en = 0;
            end
            losses = (alu_pend && !alu_win) ? ((losses < 3) ? losses + 1 : 3) : 0;
            if (alu_win) alu_pend = 0;
            if (lsu_win) lsu_pend = 0;
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_both_valid();
        test_starvation();
        test_scoreboard();
        test_set_clear_flush();
        test_zero_rd();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
Write-back controller for the 32x32 integer register file. It arbitrates the register file's single write port between the ALU and the load/store unit (LSU), and registers the winning write onto the port. It also keeps a pending-write scoreboard so the issue stage can stall on read-after-write hazards. It sits between the execute/memory stages and the register file write port.

Parameters:
XLEN, 32, data width of write-back values
NUM_REGS, 32, number of architectural registers; x0 is hardwired zero
STARVE_LIMIT, 3, consecutive ALU losses after which the ALU is forced to win

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous reset, active-low
alu_valid_i  input  1  ALU write-back request
alu_ready_o  output  1  ALU request granted this cycle
alu_rd_i  input  5  ALU destination register
alu_data_i  input  XLEN  ALU result
lsu_valid_i  input  1  LSU write-back request
lsu_ready_o  output  1  LSU request granted this cycle
lsu_rd_i  input  5  LSU destination register
lsu_data_i  input  XLEN  load result
sb_set_i  input  1  issue stage marks a destination as pending
sb_set_rd_i  input  5  register to mark pending
flush_i  input  1  pipeline flush; clears the scoreboard
rs1_addr_i  input  5  issue-stage source 1 query
rs2_addr_i  input  5  issue-stage source 2 query
rs1_busy_o  output  1  source 1 has a pending write
rs2_busy_o  output  1  source 2 has a pending write
rf_wr_en_o  output  1  register file write enable
rf_rd_addr_o  output  5  register file write address
rf_wr_data_o  output  XLEN  register file write data

Behaviour:
- Handshake: a transfer occurs when valid_i and ready_o are both high. A requester holds valid, rd and data stable until ready is asserted. Ready is combinational from valids and the starvation counter, and is 0 while reset_n is low.
- Arbitration:
  - At most one ready per cycle.
  - Default priority is LSU over ALU.
  - If alu_valid_i=1 and starve_cnt==STARVE_LIMIT, the ALU wins over the LSU.
  - A single valid requester always wins.
  - The write port never backpressures, so one transfer per cycle is always possible.
- starve_cnt, width clog2(STARVE_LIMIT+1):
  - Increments (saturating) on each cycle with alu_valid_i=1 and alu_ready_o=0.
  - Clears on an ALU transfer or when alu_valid_i=0.
  - Reset value 0.
- Output stage, one register stage:
  - A transfer in cycle N drives rf_wr_en_o=1 with that rd and data in cycle N+1, so the regfile writes at the end of N+1.
  - A cycle with no transfer drives rf_wr_en_o=0; addr and data hold their last value.
  - A transfer with rd==0 completes the handshake but drives rf_wr_en_o=0.
  - Reset: rf_wr_en_o=0, rf_rd_addr_o=0, rf_wr_data_o=0.
- Scoreboard, busy[NUM_REGS-1:0]:
  - Reset value all 0. busy[0] is constant 0.
  - Set: sb_set_i=1 with sb_set_rd_i!=0 sets busy[rd] at the next edge.
  - Clear: rf_wr_en_o=1 clears busy[rf_rd_addr_o] at the same edge the regfile writes, so a reader in the following cycle sees the new value.
  - A set and a clear of the same register in the same cycle leaves it set, because a newer producer has been issued.
  - flush_i=1 clears all busy bits at the next edge and overrides a same-cycle set. A write already in the output register still commits.
  - A second set of an already-busy register is allowed; it is cleared by the first matching commit.
- Query: rsX_busy_o = busy[rsX_addr_i]. This is combinational, and reads 0 for address 0.
- Reset mid-operation:
  - All state clears immediately.
  - An in-flight output write is dropped.
  - Requesters must re-present their requests after reset.

Decomposition:
- Shared package regfile_pkg:
  - constants XLEN, NUM_REGS, REG_ADDR_W=5
  - typedef wb_req_t (rd, data)
  - typedef enum wb_src_e {WB_NONE, WB_ALU, WB_LSU} for the grant
- One natural sub-module: wb_scoreboard, containing the busy vector with set/clear/flush priority and the two read ports. The arbiter and output register stay in regfile_wb_ctrl.

Test Plan:
- Reset, then alu_valid=1, rd=5, data=0xDEADBEEF, lsu idle -> alu_ready=1 the same cycle; next cycle rf_wr_en=1, addr=5, data=0xDEADBEEF.
- Both valid: ALU rd=3/0x11, LSU rd=4/0x22 -> LSU granted first, write x4=0x22; ALU granted the next cycle, write x3=0x11.
- LSU valid continuously with new rd each cycle, ALU valid rd=7 -> ALU loses 3 cycles; 4th cycle alu_ready=1, lsu_ready=0; starve_cnt returns to 0.
- sb_set rd=9, query rs1=9 -> busy=1. ALU writes x9 -> busy stays 1 during the rf_wr_en cycle and is 0 the cycle after.
- In one cycle, commit x9 while sb_set rd=9 -> busy[9] remains 1. Then flush_i=1 -> all busy 0. Set rd=0 -> rs1_busy(0)=0.
- Transfer with rd=0, data=0xFFFF -> handshake completes, rf_wr_en stays 0. Assert reset_n=0 while a write is in the output register -> rf_wr_en=0 immediately and the scoreboard is cleared.
